// File: rtl/feature_vec_loader_if.sv
// Bundle of the byte-stream input, vector output and status signals of the feature vector loader.
// The loader binds to the slave view; the producer/consumer environment binds to the master view.
interface feature_vec_loader_if #(
  parameter int NUM_FEAT   = 5,
  parameter int FEAT_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 8
);
  logic [FEAT_W-1:0]                 s_data;
  logic                              s_valid;
  logic                              s_last;
  logic                              s_ready;
  logic [NUM_FEAT*FEAT_W-1:0]        m_feat;
  logic [TAG_W-1:0]                  m_tag;
  logic                              m_valid;
  logic                              m_ready;
  logic                              err_short;
  logic                              err_long;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_feat, m_tag, m_valid, err_short, err_long, fifo_count
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_feat, m_tag, m_valid, err_short, err_long, fifo_count
  );
endinterface

// File: rtl/feature_vec_loader.sv
// Assembles a byte-serial feature stream into tagged NUM_FEAT-byte vectors and buffers them in a FWFT FIFO.
// Both sides use valid/ready: a transfer happens on a cycle where valid & ready are both high; nothing else moves data.
module feature_vec_loader #(
  parameter int NUM_FEAT   = 5,
  parameter int FEAT_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  feature_vec_loader_if.slave    bus,
  output logic                   dbg_state_o
);
  localparam int VW = NUM_FEAT * FEAT_W;
  localparam int IW = $clog2(NUM_FEAT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FEAT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {ASSEMBLE = 1'b0, DROP = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                started_q;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic [FEAT_W-1:0]   feat_q [NUM_FEAT];
  logic [VW-1:0]       mem_feat_q [FIFO_DEPTH];
  logic [TAG_W-1:0]    mem_tag_q [FIFO_DEPTH];
  logic [VW-1:0]       hold_feat_q;
  logic [TAG_W-1:0]    hold_tag_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [VW-1:0]       push_vec;
  logic                s_ready_w, accept, push, pop;

  // Stall only when the final byte would need a FIFO slot that is not free; a same-cycle pop does not help.
  assign s_ready_w = started_q &
                     ((state_q == DROP) || !((idx_q == LAST_IDX) && (count_q == FULL_CNT)));
  assign accept    = bus.s_valid & s_ready_w;
  assign pop       = (count_q != '0) & bus.m_ready;

  always_comb begin
    push_vec = '0;
    for (int i = 0; i < NUM_FEAT - 1; i++) begin
      push_vec[i*FEAT_W +: FEAT_W] = feat_q[i];
    end
    push_vec[VW-1 -: FEAT_W] = bus.s_data;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    push        = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    if (accept) begin
      case (state_q)
        ASSEMBLE: begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bus.s_last) begin
              push  = 1'b1;
              tag_d = tag_q + TAG_W'(1);
            end else begin
              err_long_d = 1'b1;
              state_d    = DROP;
            end
          end else if (bus.s_last) begin
            err_short_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        DROP: begin
          if (bus.s_last) begin
            state_d = ASSEMBLE;
            idx_d   = '0;
          end
        end
        default: state_d = ASSEMBLE;
      endcase
    end
  end

  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ASSEMBLE;
      idx_q       <= '0;
      tag_q       <= '0;
      started_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_feat_q <= '0;
      hold_tag_q  <= '0;
      for (int i = 0; i < NUM_FEAT; i++) feat_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_feat_q[i] <= '0;
        mem_tag_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      started_q   <= 1'b1;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      count_q     <= count_d;
      if (accept && (state_q == ASSEMBLE) && (idx_q != LAST_IDX)) begin
        feat_q[idx_q] <= bus.s_data;
      end
      if (push) begin
        mem_feat_q[wr_ptr_q] <= push_vec;
        mem_tag_q[wr_ptr_q]  <= tag_q;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      // Remember the popped head so the outputs stay put once the FIFO drains.
      if (pop) begin
        hold_feat_q <= mem_feat_q[rd_ptr_q];
        hold_tag_q  <= mem_tag_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign bus.s_ready    = s_ready_w;
  assign bus.m_valid    = (count_q != '0);
  assign bus.m_feat     = (count_q != '0) ? mem_feat_q[rd_ptr_q] : hold_feat_q;
  assign bus.m_tag      = (count_q != '0) ? mem_tag_q[rd_ptr_q] : hold_tag_q;
  assign bus.err_short  = err_short_q;
  assign bus.err_long   = err_long_q;
  assign bus.fifo_count = count_q;
  assign dbg_state_o    = state_q;
endmodule
